// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // FETCH: request outstanding at PC; HOLD: word parked while stalled;
  // DROP: waiting to swallow the ack of a wrong-path request.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // Instruction memory is word addressed; low two bits never leave the block.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: branch > jump > sequential PC+4 > hold.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] next_pc,
  output logic        redirect
);

  // Select the next PC; a taken branch overrides a simultaneous jump.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_pc  = pc;
    redirect = 1'b0;
    if (pc_src) begin
      next_pc  = branch_target;
      redirect = 1'b1;
    end else if (jump) begin
      next_pc  = jump_target;
      redirect = 1'b1;
    end else if (advance) begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding fetches to a
// variable-latency instruction memory, parks a word in a skid register while
// stalled, and discards wrong-path data after a branch/jump redirect.
// Optional build macro FETCH_PERF_EN adds fetch and stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inPCWrite,
  input  logic        inPCSrc,
  input  logic [31:0] inBranchTarget,
  input  logic        inJump,
  input  logic [31:0] inJumpTarget,
  output logic        outImemReq,
  output logic [31:0] outImemAddr,
  input  logic        inImemAck,
  input  logic [31:0] inImemData,
  output logic [31:0] outPc,
  output logic [31:0] outInstruction,
  output logic        outValid,
  output logic        outIF_Flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] outFetchCount,
  output logic [31:0] outStallCount
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_plus4, next_pc;
  logic [31:0] skid_q, instr_q, out_pc_q;
  logic        started_q, valid_q;
  logic        ack, outstanding, advance, redirect;
  logic        present_mem, present_skid, capture_skid, clear_out;

  assign pc_plus4    = pc_q + PC_INCR;
  // No request in the first cycle out of reset, so a stale ack from a
  // request issued before reset can never be mistaken for ours.
  assign outImemReq  = started_q && (state_q == FETCH);
  assign outImemAddr = word_align(pc_q);
  // An ack only means something while a request is in flight.
  assign ack         = inImemAck && started_q && (state_q != HOLD);
  assign outstanding = outImemReq || (state_q == DROP);
  assign advance     = inPCWrite && (((state_q == FETCH) && ack) || (state_q == HOLD));
  assign outIF_Flush = redirect && rst_n;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4),
    .advance       (advance),
    .pc_src        (inPCSrc),
    .branch_target (inBranchTarget),
    .jump          (inJump),
    .jump_target   (inJumpTarget),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  // Next-state and datapath control; a redirect overrides every state.
  always_comb begin
    state_d      = state_q;
    present_mem  = 1'b0;
    present_skid = 1'b0;
    capture_skid = 1'b0;
    clear_out    = 1'b0;
    if (redirect) begin
      clear_out = 1'b1;
      state_d   = (outstanding && !ack) ? DROP : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (!ack) begin
            clear_out = 1'b1;
          end else if (inPCWrite) begin
            present_mem = 1'b1;
          end else begin
            capture_skid = 1'b1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (inPCWrite) begin
            present_skid = 1'b1;
            state_d      = FETCH;
          end
        end
        DROP: begin
          clear_out = 1'b1;
          if (ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, PC and the post-reset start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      pc_q      <= next_pc;
      started_q <= 1'b1;
    end
  end

  // Skid register: parks the word that arrived while the pipe was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= NOP_INSTR;
    end else if (redirect) begin
      skid_q <= NOP_INSTR;
    end else if (capture_skid) begin
      skid_q <= inImemData;
    end
  end

  // Registered outputs toward the IF/ID latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      out_pc_q <= '0;
    end else if (clear_out) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (present_mem) begin
      valid_q  <= 1'b1;
      instr_q  <= inImemData;
      out_pc_q <= pc_plus4;
    end else if (present_skid) begin
      valid_q  <= 1'b1;
      instr_q  <= skid_q;
      out_pc_q <= pc_plus4;
    end
  end

  assign outValid       = valid_q;
  assign outInstruction = instr_q;
  assign outPc          = out_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Free-running wrap-around counters of presented words and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (present_mem || present_skid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!inPCWrite)                  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign outFetchCount = fetch_cnt_q;
  assign outStallCount = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline latch. It owns the program counter and computes the next PC from sequential, branch and jump sources. It issues one-outstanding-request fetches to a variable-latency instruction memory and presents the fetched word with its PC+4 to the IF/ID latch. It honours hazard-unit stalls, and on any redirect it discards wrong-path fetches and drives the IF flush.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inPCWrite  in  1  1 = PC may advance; 0 = stall from hazard unit
- inPCSrc  in  1  branch taken, resolved in ID
- inBranchTarget  in  32  branch target address
- inJump  in  1  jump decoded in ID
- inJumpTarget  in  32  jump target address
- outImemReq  out  1  fetch request to instruction memory
- outImemAddr  out  32  fetch address, word aligned
- inImemAck  in  1  memory returns data this cycle; legal in the request cycle (zero wait)
- inImemData  in  32  instruction word, valid when inImemAck=1
- outPc  out  32  PC+4 of the presented instruction, to IF/ID inPc
- outInstruction  out  32  presented instruction, to IF/ID inInstruction; 32'h0 (NOP) when not valid
- outValid  out  1  outInstruction is a real fetched word
- outIF_Flush  out  1  redirect this cycle, to IF/ID inIF_Flush

## Operation
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=FETCH.
  - outImemReq=0, outValid=0, outInstruction=0, outPc=0, outIF_Flush=0.
  - Skid register empty.
- States:
  - FETCH: request PC, awaiting ack.
  - HOLD: word received while stalled, kept in the skid register.
  - DROP: a redirect hit while a request was outstanding; wait for its ack and discard the data.
- FETCH:
  - outImemReq=1, outImemAddr=PC.
  - On ack with inPCWrite=1: register word and PC+4 to the outputs, set outValid=1, PC<=PC+4, stay in FETCH.
  - On ack with inPCWrite=0: capture word into skid, go to HOLD. PC and outputs hold.
  - No ack: outValid<=0, outInstruction<=0.
- HOLD:
  - outImemReq=0.
  - When inPCWrite=1: present the skid word, PC<=PC+4, go to FETCH.
- Redirect: inPCSrc=1 or inJump=1.
  - If both are asserted, inPCSrc wins.
  - Redirect takes effect regardless of inPCWrite.
  - outIF_Flush is combinational, high for the redirect cycle.
  - PC<=target, outValid<=0, outInstruction<=0, skid cleared.
  - Next state: DROP if a request is outstanding without an ack this cycle, else FETCH.
- DROP:
  - outImemReq=0.
  - On ack: discard the data, go to FETCH.
  - A second redirect in DROP updates PC and stays in DROP.
- Arithmetic: PC+4 wraps modulo 2^32. Targets are used as given, and bits[1:0] are forced to 0 on outImemAddr.

## Timing
- Zero-wait memory: a request in cycle t acked in t gives outValid=1 from edge t+1. Throughput is 1 instruction/cycle.
- An N-cycle-latency ack adds N-1 bubbles (outValid=0, NOP).
- Stall release from HOLD: the skid word appears the edge after inPCWrite returns to 1, with no re-fetch.
- Redirect in cycle t: the first target-path request goes out in t+1 from FETCH, or after the stale ack from DROP.
- rst_n deassertion mid-fetch: the memory must drop the pending ack. The block ignores an ack in the first cycle after reset.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outFetchCount[31:0], which increments on each word presented with outValid=1.
  - Adds outStallCount[31:0], which increments on each cycle with inPCWrite=0.
  - Both counters reset to 0 asynchronously and wrap.
- FETCH_PERF_EN undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Package fetch_pkg:
  - state enum {FETCH, HOLD, DROP}
  - NOP_INSTR=32'h0
  - PC_INCR=32'd4
- Sub-module next_pc_sel: combinational priority mux (branch > jump > PC+4 > hold) producing next PC and the redirect flag.
- Everything else stays in fetch_unit.

## Test plan
- Reset with RESET_PC=32'h100 and zero-wait memory -> outImemAddr 0x100, 0x104, 0x108 on consecutive cycles; outPc 0x104, 0x108, … one cycle later; outValid=1.
- Memory latency 3 cycles -> two NOP bubbles between valid words; PC advances once per ack.
- inPCWrite=0 for 4 cycles as an ack arrives -> state HOLD, outputs frozen, no outImemReq; on release the held word appears, then fetch resumes at PC+4.
- inPCSrc=1, target 0x200, during an outstanding 3-cycle request -> outIF_Flush pulses 1 cycle; the stale data is never presented; the next request is 0x200.
- inPCSrc=1 and inJump=1 in the same cycle (targets 0x300 and 0x400) -> next fetch at 0x300.
- With FETCH_PERF_EN: 10 fetches and 3 stall cycles -> outFetchCount=10, outStallCount=3; an async reset mid-run clears both.
